// File: rtl/pe_mac_drain_if.sv
// Operand, neighbour passthrough, drain-chain and status signals of one systolic PE.
// The PE connects through the slave modport; whatever drives the PE uses master.
interface pe_mac_drain_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) ();
    logic                  a_valid_i;
    logic [DATA_WIDTH-1:0] a_data_i;
    logic                  a_last_i;
    logic                  b_valid_i;
    logic [DATA_WIDTH-1:0] b_data_i;
    logic                  b_last_i;

    logic                  a_valid_o;
    logic [DATA_WIDTH-1:0] a_data_o;
    logic                  a_last_o;
    logic                  b_valid_o;
    logic [DATA_WIDTH-1:0] b_data_o;
    logic                  b_last_o;

    logic                  drain_valid_i;
    logic [ACC_WIDTH-1:0]  drain_data_i;
    logic                  drain_ready_o;
    logic                  drain_valid_o;
    logic [ACC_WIDTH-1:0]  drain_data_o;
    logic                  drain_ready_i;

    logic                  sat_o;
    logic                  ovf_o;
    logic                  last_err_o;

    modport slave (
        input  a_valid_i, a_data_i, a_last_i, b_valid_i, b_data_i, b_last_i,
        output a_valid_o, a_data_o, a_last_o, b_valid_o, b_data_o, b_last_o,
        input  drain_valid_i, drain_data_i, drain_ready_i,
        output drain_ready_o, drain_valid_o, drain_data_o,
        output sat_o, ovf_o, last_err_o
    );

    modport master (
        output a_valid_i, a_data_i, a_last_i, b_valid_i, b_data_i, b_last_i,
        input  a_valid_o, a_data_o, a_last_o, b_valid_o, b_data_o, b_last_o,
        output drain_valid_i, drain_data_i, drain_ready_i,
        input  drain_ready_o, drain_valid_o, drain_data_o,
        input  sat_o, ovf_o, last_err_o
    );
endinterface

// File: rtl/pe_mac_drain.sv
// Output-stationary systolic PE: MAC with optional saturation, registered A/B passthrough,
// local result FIFO and a single-entry drain register that also forwards upstream results.
module pe_mac_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pe_mac_drain_if.slave bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic                  w_fire;
    logic                  w_last;
    logic                  w_last_mismatch;
    logic [PROD_W-1:0]     w_a_ext;
    logic [PROD_W-1:0]     w_b_ext;
    logic [PROD_W-1:0]     w_prod;
    logic [SUM_W-1:0]      w_prod_ext;
    logic [SUM_W-1:0]      w_acc_ext;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_overflow;
    logic [ACC_WIDTH-1:0]  w_acc_next;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_loadable;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    logic                  r_a_valid;
    logic [DATA_WIDTH-1:0] r_a_data;
    logic                  r_a_last;
    logic                  r_b_valid;
    logic [DATA_WIDTH-1:0] r_b_data;
    logic                  r_b_last;

    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_sat;
    logic                  r_ovf;
    logic                  r_last_err;

    logic [ACC_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_out_valid;
    logic [ACC_WIDTH-1:0]  r_out_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_fire          = bus.a_valid_i && bus.b_valid_i;
    assign w_last          = w_fire && bus.a_last_i && bus.b_last_i;
    assign w_last_mismatch = w_fire && (bus.a_last_i != bus.b_last_i);

    // Operands are widened to the full product width first, so one multiplier's low bits
    // give the exact product in both signed and unsigned mode.
    assign w_a_ext    = {{DATA_WIDTH{SIGNED & bus.a_data_i[DATA_WIDTH-1]}}, bus.a_data_i};
    assign w_b_ext    = {{DATA_WIDTH{SIGNED & bus.b_data_i[DATA_WIDTH-1]}}, bus.b_data_i};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(SUM_W - PROD_W){SIGNED & w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_ext  = {SIGNED & r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_overflow = SIGNED ? (w_sum[SUM_W-1] != w_sum[SUM_W-2]) : w_sum[SUM_W-1];

    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (SATURATE && w_overflow) begin
            if (!SIGNED) begin
                w_acc_next = '1;
            end else if (w_sum[SUM_W-1]) begin
                w_acc_next = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
            end else begin
                w_acc_next = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
            end
        end
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_loadable = !r_out_valid || bus.drain_ready_i;
    assign w_pop      = w_loadable && !w_empty;
    assign w_push     = w_last && (!w_full || w_pop);
    assign w_drop     = w_last && w_full && !w_pop;

    // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_last  <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_last  <= 1'b0;
        end else begin
            r_a_valid <= w_fire;
            r_b_valid <= w_fire;
            if (w_fire) begin
                r_a_data <= bus.a_data_i;
                r_a_last <= bus.a_last_i;
                r_b_data <= bus.b_data_i;
                r_b_last <= bus.b_last_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_ovf      <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            if (w_fire) begin
                r_acc <= w_last ? '0 : w_acc_next;
            end
            if (w_fire && SATURATE && w_overflow) begin
                r_sat <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_last_mismatch) begin
                r_last_err <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push) begin
            r_mem[r_wr_ptr] <= w_acc_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Local results win the drain register; upstream data only moves once our FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_loadable) begin
            if (!w_empty) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[r_rd_ptr];
            end else if (bus.drain_valid_i) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.drain_data_i;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.a_valid_o     = r_a_valid;
    assign bus.a_data_o      = r_a_data;
    assign bus.a_last_o      = r_a_last;
    assign bus.b_valid_o     = r_b_valid;
    assign bus.b_data_o      = r_b_data;
    assign bus.b_last_o      = r_b_last;
    assign bus.drain_ready_o = rst_ni && w_loadable && w_empty;
    assign bus.drain_valid_o = r_out_valid;
    assign bus.drain_data_o  = r_out_data;
    assign bus.sat_o         = r_sat;
    assign bus.ovf_o         = r_ovf;
    assign bus.last_err_o    = r_last_err;
endmodule

// File: tb/tb_pe_mac_drain.sv
// Directed and randomized checks of pe_mac_drain against an arithmetic reference model.
// Three instances: the default 40-bit PE plus 32-bit saturating and wrapping variants.
`timescale 1ns/1ps
module tb_pe_mac_drain;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int NW = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    longint exp_q[$];

    always #5 clk_i = ~clk_i;

    pe_mac_drain_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
    pe_mac_drain_if #(.DATA_WIDTH(DW), .ACC_WIDTH(NW)) bus_sat ();
    pe_mac_drain_if #(.DATA_WIDTH(DW), .ACC_WIDTH(NW)) bus_wrap ();

    pe_mac_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b1), .FIFO_DEPTH(2))
        dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
    pe_mac_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(NW), .SIGNED(1'b1), .SATURATE(1'b1), .FIFO_DEPTH(2))
        dut_sat (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_sat));
    pe_mac_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(NW), .SIGNED(1'b1), .SATURATE(1'b0), .FIFO_DEPTH(2))
        dut_wrap (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_wrap));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accumulation step in plain integer arithmetic over a w-bit signed accumulator.
    function automatic longint mac_ref(input longint acc, input longint prod, input int w,
                                       input bit sat, output bit clamped);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        s = acc + prod;
        clamped = 1'b0;
        if (s > hi || s < lo) begin
            if (sat) begin
                clamped = 1'b1;
                s = (s > hi) ? hi : lo;
            end else begin
                s = s & ((longint'(1) <<< w) - 1);
                if (s > hi) s = s - (longint'(1) <<< w);
            end
        end
        return s;
    endfunction

    function automatic logic [63:0] to_acc(input longint v, input int w);
        return 64'(v & ((longint'(1) <<< w) - 1));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input int a, input int b, input bit al, input bit bl);
        bus.a_valid_i = 1'b1;
        bus.b_valid_i = 1'b1;
        bus.a_data_i  = DW'(a);
        bus.b_data_i  = DW'(b);
        bus.a_last_i  = al;
        bus.b_last_i  = bl;
    endtask

    task automatic idle();
        bus.a_valid_i = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.a_last_i  = 1'b0;
        bus.b_last_i  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"}, 64'({bus.a_valid_o, bus.a_last_o, bus.b_valid_o, bus.b_last_o,
              bus.drain_valid_o, bus.drain_ready_o, bus.sat_o, bus.ovf_o, bus.last_err_o}), 64'd0);
        check({tag, "_adata"}, 64'(bus.a_data_o), 64'd0);
        check({tag, "_bdata"}, 64'(bus.b_data_o), 64'd0);
        check({tag, "_ddata"}, 64'(bus.drain_data_o), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (mon_en && bus.drain_valid_o && bus.drain_ready_i) begin
            if (exp_q.size() == 0) check("rand_extra", 64'(exp_q.size()), 64'd1);
            else check("rand_data", 64'(bus.drain_data_o), to_acc(exp_q.pop_front(), AW));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc;
        longint a_sat;
        longint a_wrap;
        bit     c;
        int     len;
        int     low_run;
        int     waited;
        logic signed [DW-1:0] ra;
        logic signed [DW-1:0] rb;

        idle();
        bus.drain_valid_i = 1'b0;
        bus.drain_data_i  = '0;
        bus.drain_ready_i = 1'b1;
        bus_sat.a_valid_i = 1'b0;  bus_sat.b_valid_i = 1'b0;
        bus_sat.a_last_i  = 1'b0;  bus_sat.b_last_i  = 1'b0;
        bus_sat.a_data_i  = '0;    bus_sat.b_data_i  = '0;
        bus_sat.drain_valid_i = 1'b0; bus_sat.drain_data_i = '0; bus_sat.drain_ready_i = 1'b1;
        bus_wrap.a_valid_i = 1'b0; bus_wrap.b_valid_i = 1'b0;
        bus_wrap.a_last_i  = 1'b0; bus_wrap.b_last_i  = 1'b0;
        bus_wrap.a_data_i  = '0;   bus_wrap.b_data_i  = '0;
        bus_wrap.drain_valid_i = 1'b0; bus_wrap.drain_data_i = '0; bus_wrap.drain_ready_i = 1'b1;

        // Reset with a live last-fire on the inputs: it must be ignored.
        rst_ni = 1'b0;
        beat(11, 12, 1'b1, 1'b1);
        tick();
        tick();
        check_reset_state("reset");
        rst_ni = 1'b1;
        idle();
        #1;
        check("ready_idle", 64'(bus.drain_ready_o), 64'd1);

        // Dot product {1,2,3,4}.{5,6,7,8} = 70, plus passthrough lag.
        for (int i = 0; i < 4; i++) begin
            beat(i + 1, i + 5, i == 3, i == 3);
            tick();
            check("pass_a_data", 64'(bus.a_data_o), 64'(i + 1));
            check("pass_b_data", 64'(bus.b_data_o), 64'(i + 5));
            check("pass_valid", 64'({bus.a_valid_o, bus.b_valid_o}), 64'd3);
        end
        idle();
        check("dot_t1_valid", 64'(bus.drain_valid_o), 64'd0);
        tick();
        check("pass_hold_data", 64'(bus.a_data_o), 64'd4);
        check("pass_idle_valid", 64'(bus.a_valid_o), 64'd0);
        check("dot_t2_valid", 64'(bus.drain_valid_o), 64'd1);
        check("dot_result", 64'(bus.drain_data_o), 64'd70);
        tick();
        check("dot_drained", 64'(bus.drain_valid_o), 64'd0);

        // Signed mix then an immediate second product.
        beat(-3, 7, 1'b0, 1'b0); tick();
        beat(4, -2, 1'b1, 1'b1); tick();
        beat(2, 2, 1'b1, 1'b1);  tick();
        idle();
        check("signed_valid", 64'(bus.drain_valid_o), 64'd1);
        check("signed_result", 64'(bus.drain_data_o), to_acc(-29, AW));
        tick();
        check("second_result", 64'(bus.drain_data_o), 64'd4);
        tick();
        check("second_drained", 64'(bus.drain_valid_o), 64'd0);

        // Backpressure: four single-beat products into a 2-deep FIFO plus output register.
        bus.drain_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            beat(k, 1, 1'b1, 1'b1);
            tick();
            if (k == 3) check("ovf_before_drop", 64'(bus.ovf_o), 64'd0);
        end
        idle();
        check("ovf_set", 64'(bus.ovf_o), 64'd1);
        check("stall_valid", 64'(bus.drain_valid_o), 64'd1);
        check("stall_head", 64'(bus.drain_data_o), 64'd1);
        check("stall_ready_o", 64'(bus.drain_ready_o), 64'd0);
        bus.drain_ready_i = 1'b1;
        tick();
        check("order_2", 64'(bus.drain_data_o), 64'd2);
        tick();
        check("order_3", 64'(bus.drain_data_o), 64'd3);
        tick();
        check("dropped_4", 64'(bus.drain_valid_o), 64'd0);

        // Drain chain: local result beats upstream data.
        beat(9, 1, 1'b1, 1'b1);
        tick();
        idle();
        bus.drain_valid_i = 1'b1;
        bus.drain_data_i  = AW'(8'hAA);
        #1;
        check("chain_ready_busy", 64'(bus.drain_ready_o), 64'd0);
        tick();
        check("chain_local", 64'(bus.drain_data_o), 64'd9);
        check("chain_ready_free", 64'(bus.drain_ready_o), 64'd1);
        tick();
        check("chain_upstream", 64'(bus.drain_data_o), 64'hAA);
        bus.drain_data_i = AW'(8'h55);
        tick();
        check("chain_pass", 64'(bus.drain_data_o), 64'h55);
        bus.drain_valid_i = 1'b0;
        tick();
        check("chain_drained", 64'(bus.drain_valid_o), 64'd0);

        // Mismatched last: flagged, not pushed, sum continues.
        check("last_err_clear", 64'(bus.last_err_o), 64'd0);
        beat(3, 4, 1'b1, 1'b0); tick();
        check("last_err_set", 64'(bus.last_err_o), 64'd1);
        beat(1, 1, 1'b1, 1'b1); tick();
        idle();
        check("mismatch_no_push", 64'(bus.drain_valid_o), 64'd0);
        tick();
        check("mismatch_sum", 64'(bus.drain_data_o), 64'd13);
        tick();

        // Reset mid-sum discards the partial sum and clears sticky flags.
        beat(5, 5, 1'b0, 1'b0); tick();
        rst_ni = 1'b0;
        beat(7, 7, 1'b1, 1'b1); tick();
        check_reset_state("midreset");
        rst_ni = 1'b1;
        beat(2, 3, 1'b1, 1'b1); tick();
        idle(); tick();
        check("after_reset_sum", 64'(bus.drain_data_o), 64'd6);
        tick();

        // 32-bit accumulators: three 32767*32767 steps, saturating vs wrapping.
        a_sat = 0;
        a_wrap = 0;
        for (int i = 0; i < 3; i++) begin
            bus_sat.a_valid_i = 1'b1;  bus_sat.b_valid_i = 1'b1;
            bus_sat.a_data_i  = 16'h7FFF; bus_sat.b_data_i = 16'h7FFF;
            bus_sat.a_last_i  = (i == 2); bus_sat.b_last_i = (i == 2);
            bus_wrap.a_valid_i = 1'b1; bus_wrap.b_valid_i = 1'b1;
            bus_wrap.a_data_i  = 16'h7FFF; bus_wrap.b_data_i = 16'h7FFF;
            bus_wrap.a_last_i  = (i == 2); bus_wrap.b_last_i = (i == 2);
            a_sat  = mac_ref(a_sat, longint'(32767) * 32767, NW, 1'b1, c);
            a_wrap = mac_ref(a_wrap, longint'(32767) * 32767, NW, 1'b0, c);
            tick();
            if (i == 1) check("sat_not_yet", 64'(bus_sat.sat_o), 64'd0);
        end
        bus_sat.a_valid_i = 1'b0;  bus_sat.b_valid_i = 1'b0;
        bus_wrap.a_valid_i = 1'b0; bus_wrap.b_valid_i = 1'b0;
        tick();
        check("sat_result", 64'(bus_sat.drain_data_o), to_acc(a_sat, NW));
        check("sat_flag", 64'(bus_sat.sat_o), 64'd1);
        check("wrap_result", 64'(bus_wrap.drain_data_o), to_acc(a_wrap, NW));
        check("wrap_flag", 64'(bus_wrap.sat_o), 64'd0);

        // Randomized products with short downstream stalls, checked by the monitor.
        rst_ni = 1'b0; idle(); tick();
        rst_ni = 1'b1;
        mon_en = 1'b1;
        low_run = 0;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(4, 7);
            acc = 0;
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    bus.a_valid_i = 1'($urandom_range(0, 1));
                    bus.a_data_i  = DW'($urandom);
                    bus.b_data_i  = DW'($urandom);
                    bus.drain_ready_i = ($urandom_range(0, 3) != 0) || (low_run >= 2);
                    low_run = bus.drain_ready_i ? 0 : low_run + 1;
                    tick();
                end
                ra = DW'($urandom);
                rb = DW'($urandom);
                beat(int'(ra), int'(rb), j == len - 1, j == len - 1);
                acc = mac_ref(acc, longint'(ra) * longint'(rb), AW, 1'b1, c);
                if (j == len - 1) exp_q.push_back(acc);
                bus.drain_ready_i = ($urandom_range(0, 3) != 0) || (low_run >= 2);
                low_run = bus.drain_ready_i ? 0 : low_run + 1;
                tick();
            end
        end
        idle();
        bus.drain_ready_i = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            tick();
            waited++;
        end
        tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_flags", 64'({bus.sat_o, bus.ovf_o, bus.last_err_o}), 64'd0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
